// File: rtl/div_seq_ctrl_if.sv
// Request/response bus between the pipeline and div_seq_ctrl.
// Signal names are written from the controller's point of view:
// _i is driven by the pipeline and _o by the controller.
interface div_seq_ctrl_if #(
    parameter int TAG_W = 5
) ();
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       op_i;
    logic [31:0]      rs1_i;
    logic [31:0]      rs2_i;
    logic [TAG_W-1:0] tag_i;
    logic             flush_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [31:0]      result_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;

    modport slave (
        input  req_valid_i, op_i, rs1_i, rs2_i, tag_i, flush_i, resp_ready_i,
        output req_ready_o, resp_valid_o, result_o, tag_o, busy_o
    );

    modport master (
        output req_valid_i, op_i, rs1_i, rs2_i, tag_i, flush_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, result_o, tag_o, busy_o
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// RV32M divide/remainder sequencer in front of an unsigned restoring divider.
// Converts signed operands to magnitudes, launches the divider, restores
// result signs and substitutes the divide-by-zero / signed-overflow results.
// Optional macro DIV_SEQ_FASTPATH_EN: divide-by-zero and signed-overflow
// requests are answered directly from IDLE without using the divider.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request, req_ready_o high
// LAUNCH | div_start_o pulsed with registered magnitudes
// WAIT   | waiting for div_done_i
// FIX    | sign correction, special-case substitution, result select
// RESP   | resp_valid_o held until resp_ready_i
// DRAIN  | request flushed, waiting for the divider to finish
module div_seq_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    div_seq_ctrl_if.slave      bus,
    output logic               div_start_o,
    output logic [31:0]        div_dividend_o,
    output logic [31:0]        div_divisor_o,
    input  logic               div_done_i,
    input  logic [31:0]        div_quotient_i,
    input  logic [63:0]        div_remainder_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_FIX,
        ST_RESP,
        ST_DRAIN
    } state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic             sign1_q, sign2_q;
    logic             dz_q, ovf_q;
    logic [31:0]      mag1_q, mag2_q;
    logic [31:0]      quo_q, rem_q;
    logic [31:0]      result_q;
    logic             resp_valid_q;
    logic             start_q;

    logic             accept;
    logic             in_signed, in_dz, in_ovf;
    logic [31:0]      in_mag1, in_mag2;
    logic [31:0]      fix_result_d;

    // Only the low word of the divider remainder carries the result.
    logic             unused_rem_hi;
    assign unused_rem_hi = ^div_remainder_i[63:32];

    // A flush in IDLE blocks acceptance, so ready is withdrawn while it is high.
    assign bus.req_ready_o  = (state_q == ST_IDLE) && !bus.flush_i;
    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.result_o     = result_q;
    assign bus.tag_o        = tag_q;
    assign div_start_o      = start_q;
    assign div_dividend_o   = mag1_q;
    assign div_divisor_o    = mag2_q;

    assign accept    = bus.req_valid_i && bus.req_ready_o;
    assign in_signed = !bus.op_i[0];
    assign in_dz     = (bus.rs2_i == 32'h0);
    assign in_ovf    = in_signed && (bus.rs1_i == 32'h8000_0000) &&
                       (bus.rs2_i == 32'hFFFF_FFFF);
    assign in_mag1   = (in_signed && bus.rs1_i[31]) ? -bus.rs1_i : bus.rs1_i;
    assign in_mag2   = (in_signed && bus.rs2_i[31]) ? -bus.rs2_i : bus.rs2_i;

`ifdef DIV_SEQ_FASTPATH_EN
    logic [31:0] fast_result_d;

    // Special-case result straight from the request operands.
    always_comb begin
        fast_result_d = 32'h0;
        if (in_dz)
            fast_result_d = bus.op_i[1] ? bus.rs1_i : 32'hFFFF_FFFF;
        else
            fast_result_d = bus.op_i[1] ? 32'h0 : 32'h8000_0000;
    end
`endif

    // Restore signs on the divider outputs and substitute the special cases.
    always_comb begin
        logic        is_signed;
        logic [31:0] quo_fix;
        logic [31:0] rem_fix;
        is_signed = !op_q[0];
        quo_fix   = (is_signed && (sign1_q ^ sign2_q)) ? -quo_q : quo_q;
        rem_fix   = (is_signed && sign1_q) ? -rem_q : rem_q;
        if (dz_q) begin
            quo_fix = 32'hFFFF_FFFF;
            rem_fix = sign1_q ? -mag1_q : mag1_q;
        end else if (ovf_q) begin
            quo_fix = 32'h8000_0000;
            rem_fix = 32'h0;
        end
        fix_result_d = op_q[1] ? rem_fix : quo_fix;
    end

    // Sequencer state, captured operands and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            op_q         <= 2'b00;
            tag_q        <= '0;
            sign1_q      <= 1'b0;
            sign2_q      <= 1'b0;
            dz_q         <= 1'b0;
            ovf_q        <= 1'b0;
            mag1_q       <= 32'h0;
            mag2_q       <= 32'h0;
            quo_q        <= 32'h0;
            rem_q        <= 32'h0;
            result_q     <= 32'h0;
            resp_valid_q <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= bus.op_i;
                        tag_q   <= bus.tag_i;
                        sign1_q <= in_signed && bus.rs1_i[31];
                        sign2_q <= in_signed && bus.rs2_i[31];
                        dz_q    <= in_dz;
                        ovf_q   <= in_ovf;
                        mag1_q  <= in_mag1;
                        mag2_q  <= in_mag2;
`ifdef DIV_SEQ_FASTPATH_EN
                        if (in_dz || in_ovf) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            result_q     <= fast_result_d;
                        end else begin
                            state_q <= ST_LAUNCH;
                            start_q <= 1'b1;
                        end
`else
                        state_q <= ST_LAUNCH;
                        start_q <= 1'b1;
`endif
                    end
                end
                ST_LAUNCH: begin
                    state_q <= bus.flush_i ? ST_DRAIN : ST_WAIT;
                end
                ST_WAIT: begin
                    // A flush coinciding with done has nothing left to drain.
                    if (bus.flush_i) begin
                        state_q <= div_done_i ? ST_IDLE : ST_DRAIN;
                    end else if (div_done_i) begin
                        quo_q   <= div_quotient_i;
                        rem_q   <= div_remainder_i[31:0];
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (bus.flush_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        result_q     <= fix_result_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.flush_i || bus.resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (div_done_i)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 Parameter TAG_W, default 5: width of the destination-register tag carried alongside each request.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 req_valid_i  input  1  pipeline presents a divide request.
REQ-005 req_ready_o  output  1  block accepts the request this cycle (high only in IDLE).
REQ-006 op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
REQ-007 rs1_i / rs2_i  input  32 each  dividend / divisor operands.
REQ-008 tag_i  input  TAG_W  destination tag; returned unchanged on tag_o.
REQ-009 flush_i  input  1  pipeline kill; discards the in-flight request.
REQ-010 resp_valid_o  output  1  result valid; resp_ready_i  input  1  consumer takes result.
REQ-011 result_o  output  32 final RV32M result; tag_o  output  TAG_W.
REQ-012 busy_o  output  1  high in every state except IDLE; drives pipeline stall.
REQ-013 div_start_o  output  1; div_dividend_o / div_divisor_o  output  32  unsigned operands to the restoring divider.
REQ-014 div_done_i  input  1; div_quotient_i  input  32; div_remainder_i  input  64 (bits [31:0] used) from divider.

Function
REQ-015 FSM states IDLE, LAUNCH, WAIT, FIX, RESP, DRAIN; transfer = valid & ready on the same edge.
REQ-016 IDLE: on acceptance, register op, tag, operand signs, and magnitudes (two's-complement negate when signed op and operand bit 31 set; 0x80000000 stays 0x80000000); go to LAUNCH.
REQ-017 LAUNCH: div_start_o high for exactly one cycle with div_dividend_o/div_divisor_o holding registered magnitudes; next state WAIT.
REQ-018 div_dividend_o/div_divisor_o stay stable from LAUNCH until div_done_i observed.
REQ-019 WAIT: on div_done_i high, capture quotient and remainder[31:0]; go to FIX.
REQ-020 FIX: signed ops negate quotient when operand signs differ, negate remainder when dividend negative; select quotient (DIV/DIVU) or remainder (REM/REMU); go to RESP.
REQ-021 Divide by zero: quotient 0xFFFFFFFF, remainder = rs1, any op.
REQ-022 Signed overflow (rs1 0x80000000, rs2 0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
REQ-023 RESP: resp_valid_o high, result_o/tag_o held stable until resp_ready_i; on transfer go to IDLE; no new request accepted in the same cycle.
REQ-024 flush_i in LAUNCH or WAIT: go to DRAIN; div_done_i in DRAIN returns to IDLE with no response; flush_i in FIX or RESP: drop result, go to IDLE; flush_i in IDLE ignored (request that cycle not accepted).
REQ-025 flush_i has priority over div_done_i and resp_ready_i in the same cycle.
REQ-026 Normal latency: acceptance edge to resp_valid_o = divider latency + 3 cycles.

Reset
REQ-027 rst_ni low at a clock edge: state IDLE, resp_valid_o, div_start_o, busy_o 0, result_o, tag_o, div operand outputs 0, regardless of current state.
REQ-028 req_ready_o is 1 in the first cycle after reset deassertion.

Configuration
REQ-029 Macro DIV_SEQ_FASTPATH_EN defined: divide-by-zero and signed-overflow requests bypass LAUNCH/WAIT/FIX, go IDLE to RESP, resp_valid_o high the cycle after acceptance, div_start_o never asserted.
REQ-030 Macro undefined: all requests use the divider; REQ-021/022 results substituted in FIX; latency per REQ-026.

Verification
REQ-031 DIV rs1 0xFFFFFFF9 (-7), rs2 2 -> result_o 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
REQ-032 REMU rs1 100, rs2 7 -> result_o 2; DIVU same -> 14; tag_i 0x13 -> tag_o 0x13.
REQ-033 DIV rs1 5, rs2 0 -> 0xFFFFFFFF; REM rs1 0x80000000, rs2 0xFFFFFFFF -> 0; with DIV_SEQ_FASTPATH_EN response 1 cycle after acceptance, no div_start_o.
REQ-034 resp_ready_i low 5 cycles in RESP -> resp_valid_o, result_o, tag_o unchanged; req_ready_o low throughout.
REQ-035 flush_i in WAIT -> no resp_valid_o; busy_o high until div_done_i; next request DIVU 9/3 -> 3.
REQ-036 rst_ni low during WAIT -> outputs 0 next edge; subsequent DIV 20/-4 -> 0xFFFFFFFB.
